// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command request and status handshake between a command source and the PS/2 transmitter
interface ps2_host_tx_if;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  modport master (output i_valid, i_data, input o_ready, o_busy, o_done, o_err);
  modport slave  (input i_valid, i_data, output o_ready, o_busy, o_done, o_err);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with clock inhibit, device ACK check and timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  ps2_host_tx_if.slave bus,
  input  logic         i_ps2_clk,
  input  logic         i_ps2_dat,
  output logic         o_ps2_clk_low,
  output logic         o_ps2_dat_low
);
  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, INHIBIT, RELEASE, SHIFT, ACK, WAIT_IDLE} state_t;
  state_t        r_state;
  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_prev;
  logic [IW-1:0] r_inh_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_shift;
  logic          r_ok;
  logic          w_sync_clk;
  logic          w_sync_dat;
  logic          w_fall;
  logic          w_timeout;
  assign w_sync_clk = r_clk_sync[1];
  assign w_sync_dat = r_dat_sync[1];
  assign w_fall     = r_clk_prev & ~w_sync_clk;
  assign w_timeout  = r_to_cnt == TW'(TIMEOUT_CYCLES - 1);
  // Two-flop synchronisers on both pins; idle-high reset avoids a spurious fall after reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
      r_clk_prev <= w_sync_clk;
    end
  end
  // Request sequencer: inhibit, start bit, shift on device clock falls, ACK sample, wait for idle lines
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      bus.o_ready   <= 1'b1;
      bus.o_busy    <= 1'b0;
      bus.o_done    <= 1'b0;
      bus.o_err     <= 1'b0;
      o_ps2_clk_low <= 1'b0;
      o_ps2_dat_low <= 1'b0;
      r_inh_cnt     <= '0;
      r_to_cnt      <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_ok          <= 1'b0;
    end else begin
      bus.o_done <= 1'b0;
      bus.o_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          bus.o_ready <= 1'b1;
          if (bus.o_ready && bus.i_valid) begin
            r_shift       <= {1'b1, ~^bus.i_data, bus.i_data};
            bus.o_ready   <= 1'b0;
            bus.o_busy    <= 1'b1;
            o_ps2_clk_low <= 1'b1;
            r_inh_cnt     <= '0;
            r_state       <= INHIBIT;
          end
        end
        INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + 1'b1;
          if (r_inh_cnt == IW'(INHIBIT_CYCLES - 2)) begin
            o_ps2_dat_low <= 1'b1;
            r_state       <= RELEASE;
          end
        end
        RELEASE: begin
          o_ps2_clk_low <= 1'b0;
          r_bit_cnt     <= '0;
          r_to_cnt      <= '0;
          r_state       <= SHIFT;
        end
        SHIFT, ACK: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          if (w_timeout) begin
            o_ps2_clk_low <= 1'b0;
            o_ps2_dat_low <= 1'b0;
            bus.o_err     <= 1'b1;
            bus.o_busy    <= 1'b0;
            r_state       <= IDLE;
          end else if (w_fall && r_state == SHIFT) begin
            o_ps2_dat_low <= ~r_shift[0];
            r_shift       <= {1'b0, r_shift[9:1]};
            r_bit_cnt     <= r_bit_cnt + 1'b1;
            r_state       <= r_bit_cnt == 4'd9 ? ACK : SHIFT;
          end else if (w_fall) begin
            r_ok    <= ~w_sync_dat;
            r_state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (w_sync_clk && w_sync_dat) begin
            bus.o_done <= r_ok;
            bus.o_err  <= ~r_ok;
            bus.o_busy <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-side BFM and frame model checking the PS/2 host transmitter
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 2000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bfm_clk_low = 1'b0;
  logic bfm_dat_low = 1'b0;
  logic clk_low;
  logic dat_low;
  logic ps2_clk;
  logic ps2_dat;
  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err = 0;
  int cyc = 0;
  logic prev_pulse = 1'b0;
  ps2_host_tx_if bus();
  assign ps2_clk = ~(clk_low | bfm_clk_low);
  assign ps2_dat = ~(dat_low | bfm_dat_low);
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus.slave),
    .i_ps2_clk(ps2_clk),
    .i_ps2_dat(ps2_dat),
    .o_ps2_clk_low(clk_low),
    .o_ps2_dat_low(dat_low)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (prev_pulse) chk("ready_after_pulse", bus.o_ready, 1);
    if (bus.o_done || bus.o_err) chk("pulse_exclusive", bus.o_done & bus.o_err, 0);
    if (bus.o_done) n_done++;
    if (bus.o_err) n_err++;
    prev_pulse = bus.o_done | bus.o_err;
  end
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction
  task automatic send(input logic [7:0] d);
    bus.i_data = d;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask
  task automatic device(input bit ack, input int nf, output logic [9:0] bits,
                        output int inh_len, output int dat_at, output int rel);
    int t;
    bits = '0;
    inh_len = 0;
    dat_at = -1;
    t = 0;
    while (!clk_low && t < 200) begin @(negedge clk); t++; end
    while (clk_low && t < 400) begin
      inh_len++;
      if (dat_low && dat_at < 0) dat_at = inh_len;
      @(negedge clk);
      t++;
    end
    rel = cyc;
    chk("start_bit", ps2_dat, 0);
    tick(10);
    for (int k = 1; k <= nf; k++) begin
      if (k == 6) bus.i_valid = 1'b0;
      if (k == 11 && ack) begin bfm_dat_low = 1'b1; tick(5); end
      bfm_clk_low = 1'b1;
      tick(10);
      if (k <= 10) bits[k-1] = ps2_dat;
      tick(10);
      bfm_clk_low = 1'b0;
      bfm_dat_low = 1'b0;
      tick(20);
    end
  endtask
  task automatic full_frame(input logic [7:0] d, input bit ack, input string tag);
    logic [9:0] b;
    int il, da, rel, d0, e0;
    d0 = n_done;
    e0 = n_err;
    send(d);
    device(ack, 11, b, il, da, rel);
    tick(10);
    chk({tag, "_bits"}, b, frame_of(d));
    chk({tag, "_done"}, n_done - d0, ack ? 1 : 0);
    chk({tag, "_err"}, n_err - e0, ack ? 0 : 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [9:0] b;
    int il, da, rel, d0, e0, t;
    bus.i_valid = 1'b0;
    bus.i_data = 8'h00;
    tick(4);
    rst = 1'b0;
    tick(1);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_clk_low", clk_low, 0);
    chk("rst_dat_low", dat_low, 0);
    d0 = n_done;
    e0 = n_err;
    send(8'hF4);
    chk("busy_after_accept", bus.o_busy, 1);
    device(1'b1, 11, b, il, da, rel);
    tick(10);
    chk("inhibit_len", il, INH);
    chk("inhibit_dat_at", da, INH);
    chk("f4_bits", b, 10'b1_0_1111_0100);
    chk("f4_done", n_done - d0, 1);
    chk("f4_err", n_err - e0, 0);
    full_frame(8'hED, 1'b1, "ed");
    chk("ed_parity", frame_of(8'hED) >> 8, 2'b11);
    full_frame(8'hFF, 1'b0, "ff_nack");
    d0 = n_done;
    e0 = n_err;
    send(8'h00);
    device(1'b0, 5, b, il, da, rel);
    t = 0;
    while (!bus.o_err && t < 3000) begin @(negedge clk); t++; end
    chk("timeout_seen", bus.o_err, 1);
    chk("timeout_cycles", cyc - rel, TMO);
    chk("timeout_clk_rel", clk_low, 0);
    chk("timeout_dat_rel", dat_low, 0);
    tick(5);
    chk("timeout_done", n_done - d0, 0);
    chk("timeout_err", n_err - e0, 1);
    d0 = n_done;
    e0 = n_err;
    send(8'hA5);
    device(1'b0, 4, b, il, da, rel);
    chk("pre_rst_dat_low", dat_low, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_clk_low", clk_low, 0);
    chk("midrst_dat_low", dat_low, 0);
    chk("midrst_ready", bus.o_ready, 1);
    chk("midrst_busy", bus.o_busy, 0);
    tick(50);
    chk("midrst_no_done", n_done - d0, 0);
    chk("midrst_no_err", n_err - e0, 0);
    d0 = n_done;
    send(8'h3C);
    bus.i_data = 8'h33;
    bus.i_valid = 1'b1;
    device(1'b1, 11, b, il, da, rel);
    tick(30);
    chk("ignore_bits", b, frame_of(8'h3C));
    chk("ignore_done", n_done - d0, 1);
    chk("ignore_no_reaccept", bus.o_busy, 0);
    chk("ignore_clk_idle", clk_low, 0);
    for (int i = 0; i < 6; i++) begin
      full_frame(8'($urandom), 1'($urandom_range(0, 1)), "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
